// File: rtl/rx_buf_pkg.sv
// Shared types for the receive-side frame buffer.
package rx_buf_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } rx_wr_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port byte store: one write port, registered read port with read enable.
module rx_buf_ram #(
    parameter int SIZE = 2048,
    localparam int AW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [8:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [8:0]    rdata_o
);

    logic [8:0] mem_q [SIZE];
    logic [8:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_frame_buffer.sv
// Receive frame FIFO: stores MAC RX bytes, exposes only committed (good) frames to the reader.
// state   | meaning
// SYNC    | after reset, drop bytes until the first rx_last
// RECV    | store bytes of the current frame
// DISCARD | frame overflowed, ignore bytes until rx_last
module rx_frame_buffer
    import rx_buf_pkg::*;
#(
    parameter int SIZE   = 2048,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_last,
    input  logic              rx_user,
    input  logic              brx_rd_en,
    output logic [7:0]        brx_data,
    output logic              brx_valid,
    output logic              brx_last,
    output logic              brx_empty,
    output logic              brx_full,
    output logic              frame_drop,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int AW = $clog2(SIZE);
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    rx_wr_state_t      state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     cptr_q, cptr_d;
    logic [AW-1:0]     rptr_q;
    logic [AW-1:0]     wptr_inc;
    logic              wr_en;
    logic              commit;
    logic              drop_d;
    logic              frame_drop_q;
    logic              brx_valid_q;
    logic              pop;
    logic              pop_last;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [SIZE-1:0]   last_q;
    rx_entry_t         wr_entry;
    rx_entry_t         rd_entry;

    assign wptr_inc  = wptr_q + AW'(1);
    assign brx_empty = (rptr_q == cptr_q);
    assign brx_full  = (wptr_inc == rptr_q);
    assign pop       = brx_rd_en & ~brx_empty;
    // Shadow copy of the last flags lets the counter see a frame end at pop time.
    assign pop_last  = pop & last_q[rptr_q];
    assign wr_entry  = '{last: rx_last, data: rx_data};

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cptr_d  = cptr_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop_d  = 1'b0;
        if (rx_valid) begin
            case (state_q)
                SYNC: begin
                    if (rx_last) begin
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (rx_last && rx_user) begin
                        wptr_d = cptr_q;
                        drop_d = 1'b1;
                    end else if (!brx_full) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_inc;
                        if (rx_last) begin
                            cptr_d = wptr_inc;
                            commit = 1'b1;
                        end
                    end else if (rx_last) begin
                        wptr_d = cptr_q;
                        drop_d = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (rx_last) begin
                        wptr_d  = cptr_q;
                        drop_d  = 1'b1;
                        state_d = RECV;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (commit && !pop_last) begin
            if (fcnt_q != FCNT_MAX) begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end else if (!commit && pop_last) begin
            if (fcnt_q != '0) begin
                fcnt_d = fcnt_q - FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            wptr_q       <= '0;
            cptr_q       <= '0;
            rptr_q       <= '0;
            frame_drop_q <= 1'b0;
            brx_valid_q  <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cptr_q       <= cptr_d;
            frame_drop_q <= drop_d;
            brx_valid_q  <= pop;
            fcnt_q       <= fcnt_d;
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            last_q[wptr_q] <= rx_last;
        end
    end

    rx_buf_ram #(
        .SIZE (SIZE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .re_i    (pop),
        .raddr_i (rptr_q),
        .rdata_o (rd_entry)
    );

    assign brx_data    = rd_entry.data;
    assign brx_last    = rd_entry.last;
    assign brx_valid   = brx_valid_q;
    assign frame_drop  = frame_drop_q;
    assign frame_count = fcnt_q;

endmodule
